// File: rtl/rom_bootloader_if.sv
// rom_bootloader_if: byte-stream input, ROM write bus and CPU control bundle.
// Ports (slave = bootloader): byte_valid/byte_data in, byte_ready out,
//   bootload_status/rom_we/rom_addr/rom_data out, cpu_reset/load_done/load_error out.
interface rom_bootloader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        bootload_status;
    logic        rom_we;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, bootload_status, rom_we, rom_addr, rom_data,
        output cpu_reset, load_done, load_error
    );

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, bootload_status, rom_we, rom_addr, rom_data,
        input  cpu_reset, load_done, load_error
    );
endinterface

// File: rtl/rom_bootloader.sv
// rom_bootloader: receives a framed byte stream (HDR, N, N x {hi,lo}[, chk]),
// writes 16-bit words into the instruction ROM, then releases the CPU reset.
// Ports: clock, reset (sync, active-low), bus (rom_bootloader_if.slave).
// Option: define BOOTLOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module rom_bootloader #(
    parameter logic [7:0] START_ADDR    = 8'h00,
    parameter logic [7:0] HDR_BYTE      = 8'hA5,
    parameter int         RELEASE_DELAY = 4
) (
    input logic              clock,
    input logic              reset,
    rom_bootloader_if.slave  bus
);
    typedef enum logic [3:0] {
        S_HDR, S_CNT, S_HI, S_LO, S_WR, S_CHK, S_HOLD, S_RUN, S_ERR
    } state_t;

    // Counter starts at DELAY-1 and HOLD exits on zero: DELAY cycles in HOLD.
    localparam logic [15:0] HOLD_INIT = 16'(RELEASE_DELAY - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [7:0]  r_addr;
    logic [7:0]  r_hi;
    logic [15:0] r_hold;
    logic        r_ready;
    logic        r_bs;
    logic        r_we;
    logic [7:0]  r_rom_addr;
    logic [15:0] r_rom_data;
    logic        r_cpu_rst;
    logic        r_done;
    logic        r_err;
`ifdef BOOTLOADER_CHECKSUM_EN
    logic [7:0]  r_chk;
`endif

    logic w_xfer;
    logic w_hdr;

    assign w_xfer = bus.byte_valid & r_ready;
    assign w_hdr  = w_xfer && (bus.byte_data == HDR_BYTE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= S_HDR;
            r_cnt      <= 8'd0;
            r_addr     <= START_ADDR;
            r_hi       <= 8'd0;
            r_hold     <= 16'd0;
            r_ready    <= 1'b1;
            r_bs       <= 1'b0;
            r_we       <= 1'b0;
            r_rom_addr <= START_ADDR;
            r_rom_data <= 16'd0;
            r_cpu_rst  <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef BOOTLOADER_CHECKSUM_EN
            r_chk      <= 8'd0;
`endif
        end else begin
            r_we <= 1'b0;
            unique case (r_state)
                S_HDR: begin
                    if (w_hdr) begin
                        r_state <= S_CNT;
                        r_bs    <= 1'b1;
                    end
                end
                S_CNT: begin
                    if (w_xfer) begin
                        if (bus.byte_data == 8'd0) begin
                            r_state <= S_ERR;
                            r_bs    <= 1'b0;
                            r_err   <= 1'b1;
                        end else begin
                            r_cnt   <= bus.byte_data;
                            r_addr  <= START_ADDR;
`ifdef BOOTLOADER_CHECKSUM_EN
                            r_chk   <= bus.byte_data;
`endif
                            r_state <= S_HI;
                        end
                    end
                end
                S_HI: begin
                    if (w_xfer) begin
                        r_hi    <= bus.byte_data;
`ifdef BOOTLOADER_CHECKSUM_EN
                        r_chk   <= r_chk ^ bus.byte_data;
`endif
                        r_state <= S_LO;
                    end
                end
                S_LO: begin
                    // Output address/data only change here so they hold while rom_we=0.
                    if (w_xfer) begin
                        r_rom_addr <= r_addr;
                        r_rom_data <= {r_hi, bus.byte_data};
                        r_we       <= 1'b1;
                        r_ready    <= 1'b0;
`ifdef BOOTLOADER_CHECKSUM_EN
                        r_chk      <= r_chk ^ bus.byte_data;
`endif
                        r_state    <= S_WR;
                    end
                end
                S_WR: begin
                    r_addr <= r_addr + 8'd1;
                    r_cnt  <= r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
`ifdef BOOTLOADER_CHECKSUM_EN
                        r_ready <= 1'b1;
                        r_state <= S_CHK;
`else
                        r_bs    <= 1'b0;
                        r_hold  <= HOLD_INIT;
                        r_state <= S_HOLD;
`endif
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= S_HI;
                    end
                end
`ifdef BOOTLOADER_CHECKSUM_EN
                S_CHK: begin
                    if (w_xfer) begin
                        r_bs <= 1'b0;
                        if (bus.byte_data == r_chk) begin
                            r_ready <= 1'b0;
                            r_hold  <= HOLD_INIT;
                            r_state <= S_HOLD;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_ERR;
                        end
                    end
                end
`endif
                S_HOLD: begin
                    if (r_hold == 16'd0) begin
                        r_cpu_rst <= 1'b0;
                        r_done    <= 1'b1;
                        r_ready   <= 1'b1;
                        r_state   <= S_RUN;
                    end else begin
                        r_hold <= r_hold - 16'd1;
                    end
                end
                S_RUN, S_ERR: begin
                    if (w_hdr) begin
                        r_bs      <= 1'b1;
                        r_cpu_rst <= 1'b1;
                        r_done    <= 1'b0;
                        r_err     <= 1'b0;
                        r_state   <= S_CNT;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_HDR;
                end
            endcase
        end
    end

    assign bus.byte_ready      = r_ready;
    assign bus.bootload_status = r_bs;
    assign bus.rom_we          = r_we;
    assign bus.rom_addr        = r_rom_addr;
    assign bus.rom_data        = r_rom_data;
    assign bus.cpu_reset       = r_cpu_rst;
    assign bus.load_done       = r_done;
    assign bus.load_error      = r_err;
endmodule

// File: tb/tb_rom_bootloader.sv
// tb_rom_bootloader: directed bench for rom_bootloader with a ROM model.
// Instance u0 uses START_ADDR 00, u1 uses START_ADDR FE for the wrap case.
module tb_rom_bootloader;
    localparam int DLY = 4;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       sel     = 1'b0;
    logic       r_valid = 1'b0;
    logic [7:0] r_data  = 8'h00;

    always #5 clk = ~clk;

    rom_bootloader_if if0 ();
    rom_bootloader_if if1 ();

    assign if0.byte_valid = r_valid & ~sel;
    assign if0.byte_data  = r_data;
    assign if1.byte_valid = r_valid & sel;
    assign if1.byte_data  = r_data;

    rom_bootloader #(.START_ADDR(8'h00), .HDR_BYTE(8'hA5), .RELEASE_DELAY(DLY)) u0 (
        .clock(clk), .reset(rst_n), .bus(if0.slave)
    );
    rom_bootloader #(.START_ADDR(8'hFE), .HDR_BYTE(8'hA5), .RELEASE_DELAY(DLY)) u1 (
        .clock(clk), .reset(rst_n), .bus(if1.slave)
    );

    wire w_rdy  = sel ? if1.byte_ready      : if0.byte_ready;
    wire w_bs   = sel ? if1.bootload_status : if0.bootload_status;
    wire w_cpu  = sel ? if1.cpu_reset       : if0.cpu_reset;
    wire w_done = sel ? if1.load_done       : if0.load_done;
    wire w_err  = sel ? if1.load_error      : if0.load_error;

    logic [15:0] rom0 [256];
    logic [15:0] rom1 [256];
    int we0 = 0;
    int we1 = 0;
    int n_checks = 0;
    int n_errs = 0;
    logic [15:0] wbuf [8];

    always @(negedge clk) begin
        if (if0.rom_we === 1'b1) begin
            rom0[if0.rom_addr] = if0.rom_data;
            we0++;
        end
        if (if1.rom_we === 1'b1) begin
            rom1[if1.rom_addr] = if1.rom_data;
            we1++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int maxgap);
        int gap;
        gap = int'($urandom_range(32'(maxgap)));
        r_valid = 1'b0;
        repeat (gap) @(negedge clk);
        r_valid = 1'b1;
        r_data  = b;
        for (int i = 0; i < 20; i++) begin
            if (w_rdy) break;
            @(negedge clk);
        end
        if (!w_rdy) check("ready_timeout", 32'(w_rdy), 32'd1);
        @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] n, input int maxgap);
        logic [7:0] c;
        send(8'hA5, maxgap);
        send(n, maxgap);
        c = n;
        for (int i = 0; i < int'(n); i++) begin
            send(wbuf[i][15:8], maxgap);
            send(wbuf[i][7:0], maxgap);
            c = c ^ wbuf[i][15:8] ^ wbuf[i][7:0];
        end
`ifdef BOOTLOADER_CHECKSUM_EN
        send(c, maxgap);
`endif
        r_valid = 1'b0;
    endtask

    task automatic wait_release(output int hold);
        hold = 0;
        for (int i = 0; i < 60; i++) begin
            if (!w_cpu) break;
            if (!w_bs) hold++;
            @(negedge clk);
        end
        check("release", 32'(w_cpu), 32'd0);
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_ready"}, 32'(if0.byte_ready), 32'd1);
        check({pfx, "_bs"},    32'(if0.bootload_status), 32'd0);
        check({pfx, "_we"},    32'(if0.rom_we), 32'd0);
        check({pfx, "_addr"},  32'(if0.rom_addr), 32'h00);
        check({pfx, "_data"},  32'(if0.rom_data), 32'h0000);
        check({pfx, "_cpu"},   32'(if0.cpu_reset), 32'd1);
        check({pfx, "_done"},  32'(if0.load_done), 32'd0);
        check({pfx, "_err"},   32'(if0.load_error), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold;
        int base;
        for (int i = 0; i < 256; i++) begin
            rom0[i] = 16'hDEAD;
            rom1[i] = 16'hDEAD;
        end

        // Reset values
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        check("rst1_addr", 32'(if1.rom_addr), 32'hFE);
        rst_n = 1'b1;
        @(negedge clk);

        // Junk byte in HDR is dropped
        send(8'h33, 0);
        r_valid = 1'b0;
        check("junk_bs", 32'(w_bs), 32'd0);
        check("junk_ready", 32'(w_rdy), 32'd1);

        // ADD program: seven words of 1021
        for (int i = 0; i < 7; i++) wbuf[i] = 16'h1021;
        base = we0;
        frame(8'd7, 0);
        wait_release(hold);
        check("add_hold", 32'(hold), 32'(DLY));
        check("add_we", 32'(we0 - base), 32'd7);
        for (int i = 0; i < 7; i++) check("add_rom", 32'(rom0[i]), 32'h1021);
        check("add_rom7", 32'(rom0[7]), 32'hDEAD);
        check("add_done", 32'(w_done), 32'd1);
        check("add_err", 32'(w_err), 32'd0);
        check("add_bs", 32'(w_bs), 32'd0);
        check("add_hold_addr", 32'(if0.rom_addr), 32'h06);
        check("add_hold_data", 32'(if0.rom_data), 32'h1021);

        // Reload from RUN with stalled stream
        send(8'hA5, 0);
        r_valid = 1'b0;
        check("rel_cpu", 32'(w_cpu), 32'd1);
        check("rel_done", 32'(w_done), 32'd0);
        check("rel_bs", 32'(w_bs), 32'd1);
        wbuf[0] = 16'hBEEF;
        wbuf[1] = 16'h0102;
        base = we0;
        send(8'd2, 5);
        for (int i = 0; i < 2; i++) begin
            send(wbuf[i][15:8], 5);
            send(wbuf[i][7:0], 5);
        end
`ifdef BOOTLOADER_CHECKSUM_EN
        send(8'h02 ^ 8'hBE ^ 8'hEF ^ 8'h01 ^ 8'h02, 5);
`endif
        r_valid = 1'b0;
        wait_release(hold);
        check("stall_hold", 32'(hold), 32'(DLY));
        check("stall_we", 32'(we0 - base), 32'd2);
        check("stall_rom0", 32'(rom0[0]), 32'hBEEF);
        check("stall_rom1", 32'(rom0[1]), 32'h0102);
        check("stall_rom2", 32'(rom0[2]), 32'h1021);
        check("stall_done", 32'(w_done), 32'd1);

`ifdef BOOTLOADER_CHECKSUM_EN
        // Bad checksum: FF instead of 27
        base = we0;
        send(8'hA5, 0);
        send(8'h01, 0);
        send(8'h12, 0);
        send(8'h34, 0);
        send(8'hFF, 0);
        r_valid = 1'b0;
        check("chk_err", 32'(w_err), 32'd1);
        check("chk_cpu", 32'(w_cpu), 32'd1);
        check("chk_done", 32'(w_done), 32'd0);
        check("chk_we", 32'(we0 - base), 32'd1);
        check("chk_rom0", 32'(rom0[0]), 32'h1234);
`endif

        // Zero count goes to error
        base = we0;
        send(8'hA5, 0);
        r_valid = 1'b0;
        check("n0_hdr_err", 32'(w_err), 32'd0);
        check("n0_hdr_cpu", 32'(w_cpu), 32'd1);
        send(8'h00, 0);
        r_valid = 1'b0;
        check("n0_err", 32'(w_err), 32'd1);
        check("n0_cpu", 32'(w_cpu), 32'd1);
        check("n0_done", 32'(w_done), 32'd0);
        check("n0_bs", 32'(w_bs), 32'd0);
        check("n0_we", 32'(we0 - base), 32'd0);
        send(8'h55, 0);
        r_valid = 1'b0;
        check("n0_junk_err", 32'(w_err), 32'd1);
        check("n0_junk_bs", 32'(w_bs), 32'd0);

        // Reset mid-load after first word of a 4-word frame
        base = we0;
        send(8'hA5, 0);
        check("mid_err_clr", 32'(w_err), 32'd0);
        send(8'h04, 0);
        send(8'h43, 0);
        send(8'h21, 0);
        r_valid = 1'b0;
        check("mid_we_pulse", 32'(if0.rom_we), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("mid");
        check("mid_we", 32'(we0 - base), 32'd1);
        check("mid_rom0", 32'(rom0[0]), 32'h4321);
        rst_n = 1'b1;
        @(negedge clk);
        wbuf[0] = 16'h5A5A;
        base = we0;
        frame(8'd1, 0);
        wait_release(hold);
        check("fresh_hold", 32'(hold), 32'(DLY));
        check("fresh_we", 32'(we0 - base), 32'd1);
        check("fresh_rom0", 32'(rom0[0]), 32'h5A5A);
        check("fresh_done", 32'(w_done), 32'd1);

        // Address wrap on instance with START_ADDR FE
        sel = 1'b1;
        @(negedge clk);
        wbuf[0] = 16'hAAAA;
        wbuf[1] = 16'hBBBB;
        wbuf[2] = 16'hCCCC;
        base = we1;
        frame(8'd3, 0);
        wait_release(hold);
        check("wrap_hold", 32'(hold), 32'(DLY));
        check("wrap_we", 32'(we1 - base), 32'd3);
        check("wrap_fe", 32'(rom1[8'hFE]), 32'hAAAA);
        check("wrap_ff", 32'(rom1[8'hFF]), 32'hBBBB);
        check("wrap_00", 32'(rom1[8'h00]), 32'hCCCC);
        check("wrap_01", 32'(rom1[8'h01]), 32'hDEAD);
        check("wrap_done", 32'(w_done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
